// File: rtl/switch_request_latch.sv
// Switch front end: sync, debounce, pending capture, valid/ack snapshot.
// Optional sticky merged-edge flag built with PENDING_OVERRUN_EN.
module switch_request_latch #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sw,
  output logic [7:0] req,
  output logic       valid,
  input  logic       ack
`ifdef PENDING_OVERRUN_EN
  ,
  output logic       overrun
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    GAP     = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [7:0]       sync1;
  logic [7:0]       sync2;
  logic [7:0]       stable;
  logic [7:0]       stable_q;
  logic [7:0]       rise_q;
  logic [7:0]       pending;
  logic [7:0]       clr;
  logic [7:0]       hi;
  logic [CNT_W-1:0] cnt [8];

  state_t state_q;
  state_t state_d;
  logic   load;
  logic   drop;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= sw;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stable <= '0;
      for (int b = 0; b < 8; b++)
        cnt[b] <= '0;
    end else begin
      for (int b = 0; b < 8; b++) begin
        if (sync2[b] != stable[b]) begin
          if (cnt[b] == CNT_MAX) begin
            stable[b] <= sync2[b];
            cnt[b]    <= '0;
          end else begin
            cnt[b] <= cnt[b] + 1'b1;
          end
        end else begin
          cnt[b] <= '0;
        end
      end
    end
  end

  // Registered rise pulse; a same-cycle set beats the ack clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      stable_q <= '0;
      rise_q   <= '0;
      pending  <= '0;
    end else begin
      stable_q <= stable;
      rise_q   <= stable & ~stable_q;
      pending  <= (pending & ~clr) | rise_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (|pending) state_d = PRESENT;
      PRESENT: if (ack) state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load  = 1'b0;
    drop  = 1'b0;
    valid = 1'b0;
    unique case (state_q)
      IDLE:    load = |pending;
      PRESENT: begin
        valid = 1'b1;
        drop  = ack;
      end
      GAP:     ;
      default: ;
    endcase
  end

  // One-hot of the highest set bit of the frozen snapshot.
  always_comb begin
    hi = '0;
    for (int b = 0; b < 8; b++) begin
      if (req[b]) begin
        hi    = '0;
        hi[b] = 1'b1;
      end
    end
  end

  assign clr = drop ? hi : 8'h00;

  always_ff @(posedge clk) begin
    if (rst || drop)
      req <= '0;
    else if (load)
      req <= pending;
  end

`ifdef PENDING_OVERRUN_EN
  always_ff @(posedge clk) begin
    if (rst)
      overrun <= 1'b0;
    else if (|(rise_q & pending))
      overrun <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_switch_request_latch.sv
// Directed bench for switch_request_latch, DEBOUNCE_CYCLES=4.
// Define PENDING_OVERRUN_EN to also cover the overrun flag.
module tb_switch_request_latch;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] sw;
  logic [7:0] req;
  logic       valid;
  logic       ack;
`ifdef PENDING_OVERRUN_EN
  logic       overrun;
`endif

  int n_cmp = 0;
  int n_err = 0;

  switch_request_latch #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sw(sw),
    .req(req),
    .valid(valid),
    .ack(ack)
`ifdef PENDING_OVERRUN_EN
    ,
    .overrun(overrun)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic settle();
    sw  = 8'h00;
    ack = 1'b0;
    tick(14);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sw  = 8'h00;
    ack = 1'b0;
    tick(3);
    n_cmp++;
    if (valid !== 1'b0 || req !== 8'h00) begin
      n_err++;
      $display("FAIL reset valid=%b req=%h need 0/00", valid, req);
    end
`ifdef PENDING_OVERRUN_EN
    n_cmp++;
    if (overrun !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ovr overrun=%b need 0", overrun);
    end
`endif
    rst = 1'b0;
  endtask

  task automatic test_single();
    sw = 8'h20;
    tick(8);
    n_cmp++;
    if (valid !== 1'b0) begin
      n_err++;
      $display("FAIL single_early valid=%b need 0", valid);
    end
    tick();
    n_cmp++;
    if (valid !== 1'b1 || req !== 8'h20) begin
      n_err++;
      $display("FAIL single_lat valid=%b req=%h need 1/20",
               valid, req);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    n_cmp++;
    if (valid !== 1'b0 || req !== 8'h00) begin
      n_err++;
      $display("FAIL single_ack valid=%b req=%h need 0/00",
               valid, req);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++;
      if (valid !== 1'b0) begin
        n_err++;
        $display("FAIL single_empty cyc%0d valid=%b need 0",
                 i, valid);
      end
    end
    settle();
  endtask

  task automatic test_glitch();
    sw = 8'h08;
    tick(3);
    sw = 8'h00;
    for (int i = 0; i < 15; i++) begin
      tick();
      n_cmp++;
      if (valid !== 1'b0) begin
        n_err++;
        $display("FAIL glitch cyc%0d valid=%b need 0", i, valid);
      end
    end
  endtask

  task automatic test_priority();
    sw = 8'h85;
    tick(9);
    n_cmp++;
    if (valid !== 1'b1 || req !== 8'h85) begin
      n_err++;
      $display("FAIL prio_85 valid=%b req=%h need 1/85",
               valid, req);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    n_cmp++;
    if (valid !== 1'b0) begin
      n_err++;
      $display("FAIL prio_gap valid=%b need 0", valid);
    end
    tick(2);
    n_cmp++;
    if (valid !== 1'b1 || req !== 8'h05) begin
      n_err++;
      $display("FAIL prio_05 valid=%b req=%h need 1/05",
               valid, req);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick(2);
    n_cmp++;
    if (valid !== 1'b1 || req !== 8'h01) begin
      n_err++;
      $display("FAIL prio_01 valid=%b req=%h need 1/01",
               valid, req);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick(5);
    n_cmp++;
    if (valid !== 1'b0) begin
      n_err++;
      $display("FAIL prio_done valid=%b need 0", valid);
    end
    settle();
  endtask

  task automatic test_freeze();
    sw = 8'h10;
    tick(9);
    n_cmp++;
    if (valid !== 1'b1 || req !== 8'h10) begin
      n_err++;
      $display("FAIL frz_10 valid=%b req=%h need 1/10",
               valid, req);
    end
    sw = 8'h12;
    for (int i = 0; i < 12; i++) begin
      tick();
      n_cmp++;
      if (valid !== 1'b1 || req !== 8'h10) begin
        n_err++;
        $display("FAIL frz_hold cyc%0d valid=%b req=%h need 1/10",
                 i, valid, req);
      end
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick(2);
    n_cmp++;
    if (valid !== 1'b1 || req !== 8'h02) begin
      n_err++;
      $display("FAIL frz_02 valid=%b req=%h need 1/02",
               valid, req);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    settle();
  endtask

  task automatic test_ack_held();
    ack = 1'b1;
    sw  = 8'h03;
    tick(9);
    n_cmp++;
    if (valid !== 1'b1 || req !== 8'h03) begin
      n_err++;
      $display("FAIL held_03 valid=%b req=%h need 1/03",
               valid, req);
    end
    tick();
    n_cmp++;
    if (valid !== 1'b0) begin
      n_err++;
      $display("FAIL held_gap valid=%b need 0", valid);
    end
    tick(2);
    n_cmp++;
    if (valid !== 1'b1 || req !== 8'h01) begin
      n_err++;
      $display("FAIL held_01 valid=%b req=%h need 1/01",
               valid, req);
    end
    tick(4);
    n_cmp++;
    if (valid !== 1'b0) begin
      n_err++;
      $display("FAIL held_done valid=%b need 0", valid);
    end
    settle();
  endtask

  task automatic test_rst_present();
    sw = 8'h40;
    tick(9);
    n_cmp++;
    if (valid !== 1'b1 || req !== 8'h40) begin
      n_err++;
      $display("FAIL rstp_40 valid=%b req=%h need 1/40",
               valid, req);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (valid !== 1'b0 || req !== 8'h00) begin
      n_err++;
      $display("FAIL rstp_drop valid=%b req=%h need 0/00",
               valid, req);
    end
    tick(8);
    n_cmp++;
    if (valid !== 1'b0) begin
      n_err++;
      $display("FAIL rstp_early valid=%b need 0", valid);
    end
    tick();
    n_cmp++;
    if (valid !== 1'b1 || req !== 8'h40) begin
      n_err++;
      $display("FAIL rstp_again valid=%b req=%h need 1/40",
               valid, req);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    settle();
  endtask

`ifdef PENDING_OVERRUN_EN
  task automatic test_overrun();
    sw = 8'h01;
    tick(6);
    sw = 8'h00;
    tick(6);
    n_cmp++;
    if (overrun !== 1'b0) begin
      n_err++;
      $display("FAIL ovr_early overrun=%b need 0", overrun);
    end
    sw = 8'h01;
    tick(6);
    tick(6);
    n_cmp++;
    if (overrun !== 1'b1) begin
      n_err++;
      $display("FAIL ovr_set overrun=%b need 1", overrun);
    end
    ack = 1'b1;
    tick(4);
    ack = 1'b0;
    n_cmp++;
    if (overrun !== 1'b1) begin
      n_err++;
      $display("FAIL ovr_sticky overrun=%b need 1", overrun);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (overrun !== 1'b0) begin
      n_err++;
      $display("FAIL ovr_clr overrun=%b need 0", overrun);
    end
    settle();
  endtask
`endif

  initial begin
    rst = 1'b1;
    sw  = 8'h00;
    ack = 1'b0;
    tick();
    test_reset();
    test_single();
    test_glitch();
    test_priority();
    test_freeze();
    test_ack_held();
    test_rst_present();
`ifdef PENDING_OVERRUN_EN
    test_overrun();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
